// File: rtl/clock_gate_controller_if.sv
// Signal bundle between domain activity monitors, the clock-gate sequencer
// and the downstream gating cells.
interface clock_gate_controller_if #(
    parameter int NUM_DOMAINS = 4
);
    logic                   force_on;
    logic [NUM_DOMAINS-1:0] idle;
    logic [NUM_DOMAINS-1:0] wake_req;
    logic [NUM_DOMAINS-1:0] gate_en;
    logic [NUM_DOMAINS-1:0] domain_ready;
    logic                   wake_busy;

    modport master (
        output force_on,
        output idle,
        output wake_req,
        input  gate_en,
        input  domain_ready,
        input  wake_busy
    );

    modport slave (
        input  force_on,
        input  idle,
        input  wake_req,
        output gate_en,
        output domain_ready,
        output wake_busy
    );
endinterface

// File: rtl/clock_gate_controller.sv
// Per-domain clock-gate sequencer: idle-timeout gating, round-robin serialised
// wake-up so only one domain at a time is inside its inrush window.
module clock_gate_controller #(
    parameter int NUM_DOMAINS = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    clock_gate_controller_if.slave  bus
);

    // state      | meaning
    // ST_RUN     | clock running, counting consecutive idle cycles
    // ST_GATED   | clock stopped, waiting for wake_req or force_on
    // ST_WAIT    | clock stopped, requesting a wake slot from the arbiter
    // ST_WAKE    | clock enabled, settling for WAKE_CYCLES before ready
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GATED = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    localparam int PTR_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_DOMAINS - 1);
    localparam logic [PTR_W:0]   PTR_WRAP  = (PTR_W+1)'(NUM_DOMAINS);

    state_t                 r_state       [NUM_DOMAINS];
    logic [CNT_W-1:0]       r_idle_cnt    [NUM_DOMAINS];
    logic [CNT_W-1:0]       r_wake_cnt    [NUM_DOMAINS];
    logic [PTR_W-1:0]       r_ptr;
    logic [NUM_DOMAINS-1:0] r_gate_en;
    logic [NUM_DOMAINS-1:0] r_domain_ready;
    logic                   r_wake_busy;

    state_t                 w_next_state    [NUM_DOMAINS];
    logic [CNT_W-1:0]       w_next_idle_cnt [NUM_DOMAINS];
    logic [CNT_W-1:0]       w_next_wake_cnt [NUM_DOMAINS];
    logic [NUM_DOMAINS-1:0] w_req;
    logic                   w_any_wake;
    logic                   w_next_any_wake;
    logic [NUM_DOMAINS-1:0] w_grant;
    logic                   w_grant_valid;
    logic [PTR_W-1:0]       w_grant_idx;
    logic [PTR_W:0]         w_scan_sum;
    logic [PTR_W-1:0]       w_scan_idx;
    logic [PTR_W-1:0]       w_next_ptr;

    always_comb begin
        w_req      = '0;
        w_any_wake = 1'b0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            w_req[i] = (r_state[i] == ST_WAIT);
            if (r_state[i] == ST_WAKE) begin
                w_any_wake = 1'b1;
            end
        end
    end

    // Round-robin search starting at the pointer; suppressed while any domain
    // is still inside its wake window so wake-ups never overlap.
    always_comb begin
        w_grant       = '0;
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_scan_sum    = '0;
        w_scan_idx    = '0;
        if (!w_any_wake) begin
            for (int k = 0; k < NUM_DOMAINS; k++) begin
                w_scan_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
                if (w_scan_sum >= PTR_WRAP) begin
                    w_scan_sum = w_scan_sum - PTR_WRAP;
                end
                w_scan_idx = w_scan_sum[PTR_W-1:0];
                if (!w_grant_valid && w_req[w_scan_idx]) begin
                    w_grant_valid          = 1'b1;
                    w_grant_idx            = w_scan_idx;
                    w_grant[w_scan_idx]    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_next_ptr = r_ptr;
        if (w_grant_valid) begin
            w_next_ptr = (w_grant_idx == PTR_LAST) ? '0 : w_grant_idx + 1'b1;
        end
    end

    always_comb begin
        w_next_any_wake = 1'b0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            w_next_state[i]    = r_state[i];
            w_next_idle_cnt[i] = '0;
            w_next_wake_cnt[i] = '0;
            case (r_state[i])
                ST_RUN: begin
                    if (bus.idle[i] && !bus.force_on) begin
                        if (r_idle_cnt[i] == IDLE_LAST) begin
                            w_next_state[i] = ST_GATED;
                        end else begin
                            w_next_idle_cnt[i] = r_idle_cnt[i] + 1'b1;
                        end
                    end
                end
                ST_GATED: begin
                    if (bus.wake_req[i] || bus.force_on) begin
                        w_next_state[i] = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_grant[i]) begin
                        w_next_state[i] = ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    if (r_wake_cnt[i] == WAKE_LAST) begin
                        w_next_state[i] = ST_RUN;
                    end else begin
                        w_next_wake_cnt[i] = r_wake_cnt[i] + 1'b1;
                    end
                end
                default: begin
                    w_next_state[i] = ST_RUN;
                end
            endcase
            if (w_next_state[i] == ST_WAKE) begin
                w_next_any_wake = 1'b1;
            end
        end
    end

    // Outputs are registered from the next state so gate_en only ever moves
    // on a clk_in edge and stays glitch-free into the latch-based gating cell.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                r_state[i]    <= ST_RUN;
                r_idle_cnt[i] <= '0;
                r_wake_cnt[i] <= '0;
            end
            r_ptr          <= '0;
            r_gate_en      <= '1;
            r_domain_ready <= '1;
            r_wake_busy    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                r_state[i]        <= w_next_state[i];
                r_idle_cnt[i]     <= w_next_idle_cnt[i];
                r_wake_cnt[i]     <= w_next_wake_cnt[i];
                r_gate_en[i]      <= (w_next_state[i] == ST_RUN) ||
                                     (w_next_state[i] == ST_WAKE);
                r_domain_ready[i] <= (w_next_state[i] == ST_RUN);
            end
            r_ptr       <= w_next_ptr;
            r_wake_busy <= w_next_any_wake;
        end
    end

    assign bus.gate_en      = r_gate_en;
    assign bus.domain_ready = r_domain_ready;
    assign bus.wake_busy    = r_wake_busy;

endmodule

// File: tb/tb_clock_gate_controller.sv
// Directed bench for clock_gate_controller: idle gating, arbitrated wake-up,
// force_on override and reset during a wake window.
module tb_clock_gate_controller;

    localparam int ND = 4;
    localparam int IC = 16;
    localparam int WC = 4;
    localparam int CW = 8;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    clock_gate_controller_if #(.NUM_DOMAINS(ND)) bus();

    clock_gate_controller #(
        .NUM_DOMAINS(ND),
        .IDLE_CYCLES(IC),
        .WAKE_CYCLES(WC),
        .CNT_W      (CW)
    ) dut (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] ge, input logic [3:0] rd,
                              input logic bz);
        check({tag, " gate_en"},      32'(bus.gate_en),      32'(ge));
        check({tag, " domain_ready"}, 32'(bus.domain_ready), 32'(rd));
        check({tag, " wake_busy"},    32'(bus.wake_busy),    32'(bz));
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        tick();
        check_outs(tag, 4'hF, 4'hF, 1'b0);
        rst_n = 1'b1;
    endtask

    // All four domains gated; wake them together and follow the 5-cycle
    // window cadence (4 wake cycles + 1 idle arbitration cycle) in order o[].
    task automatic wake_all(input int o0, input int o1, input int o2, input int o3,
                            input string tag);
        int         ord [4];
        int         busy_cnt;
        int         overlap;
        int         w;
        logic [3:0] ge;
        logic [3:0] rd;
        logic [3:0] act;
        ord      = '{o0, o1, o2, o3};
        busy_cnt = 0;
        overlap  = 0;
        bus.idle     = 4'h0;
        bus.wake_req = 4'hF;
        tick();
        bus.wake_req = 4'h0;
        check({tag, " waitgrant"}, 32'(bus.gate_en), 32'h0);
        for (int c = 1; c <= 22; c++) begin
            tick();
            if (bus.wake_busy) busy_cnt++;
            act = bus.gate_en & ~bus.domain_ready;
            if ($countones(act) > 1) overlap++;
            if ((c % 5 == 1) && (c <= 16)) begin
                w  = (c - 1) / 5;
                ge = 4'h0;
                rd = 4'h0;
                for (int k = 0; k <= w; k++) begin
                    ge = ge | (4'b0001 << ord[k]);
                    if (k < w) rd = rd | (4'b0001 << ord[k]);
                end
                check_outs($sformatf("%s window%0d", tag, w), ge, rd, 1'b1);
            end
        end
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'd16);
        check({tag, " overlap"},     32'(overlap),  32'd0);
        check({tag, " all ready"},   32'(bus.domain_ready), 32'hF);
    endtask

    initial begin
        bus.force_on = 1'b0;
        bus.idle     = 4'h0;
        bus.wake_req = 4'h0;
        tick(2);
        check_outs("reset", 4'hF, 4'hF, 1'b0);
        rst_n = 1'b1;

        // wake_req to running domains has no effect
        bus.wake_req = 4'hF;
        tick(3);
        bus.wake_req = 4'h0;
        check_outs("wake ignored in RUN", 4'hF, 4'hF, 1'b0);

        // domain 0 gates on the 16th edge of idle
        bus.idle = 4'b0001;
        tick(IC - 1);
        check_outs("d0 edge15", 4'hF, 4'hF, 1'b0);
        tick();
        check_outs("d0 edge16", 4'hE, 4'hE, 1'b0);

        // domain 1: one low cycle restarts the idle count
        bus.idle = 4'b0011;
        tick(10);
        bus.idle = 4'b0001;
        tick();
        bus.idle = 4'b0011;
        tick(IC - 1);
        check("d1 restart edge15", 32'(bus.gate_en), 32'hE);
        tick();
        check("d1 restart edge16", 32'(bus.gate_en), 32'hC);

        // domain 2: gate, then single wake pulse
        bus.idle = 4'b0111;
        tick(IC);
        check("d2 gated", 32'(bus.gate_en), 32'h8);
        bus.idle     = 4'b0011;
        bus.wake_req = 4'b0100;
        tick();
        bus.wake_req = 4'b0000;
        check_outs("d2 waitgrant", 4'h8, 4'h8, 1'b0);
        tick();
        check_outs("d2 wake start", 4'hC, 4'h8, 1'b1);
        tick(WC - 1);
        check_outs("d2 wake last", 4'hC, 4'h8, 1'b1);
        tick();
        check_outs("d2 ready", 4'hC, 4'hC, 1'b0);

        // all domains gated, pointer = 0 after reset
        do_reset("reset2");
        bus.idle = 4'hF;
        tick(IC);
        check("all gated p0", 32'(bus.gate_en), 32'h0);
        wake_all(0, 1, 2, 3, "rr p0");

        // move pointer to 2 by waking domain 1 alone
        bus.idle = 4'hF;
        tick(IC);
        check("all gated again", 32'(bus.gate_en), 32'h0);
        bus.idle     = 4'h0;
        bus.wake_req = 4'b0010;
        tick();
        bus.wake_req = 4'h0;
        tick(WC + 1);
        check("d1 alone ready", 32'(bus.domain_ready), 32'h2);
        bus.idle = 4'hF;
        tick(IC);
        check("all gated p2", 32'(bus.gate_en), 32'h0);
        wake_all(2, 3, 0, 1, "rr p2");

        // force_on wakes domains 0 and 3 in order and blocks gating
        do_reset("reset3");
        bus.idle = 4'b1001;
        tick(IC);
        check("d0 d3 gated", 32'(bus.gate_en), 32'h6);
        bus.idle     = 4'hF;
        bus.force_on = 1'b1;
        tick();
        check_outs("force waitgrant", 4'h6, 4'h6, 1'b0);
        tick();
        check_outs("force wake d0", 4'h7, 4'h6, 1'b1);
        tick(WC);
        check_outs("force d0 ready", 4'h7, 4'h7, 1'b0);
        tick();
        check_outs("force wake d3", 4'hF, 4'h7, 1'b1);
        tick(WC);
        check_outs("force d3 ready", 4'hF, 4'hF, 1'b0);
        tick(20);
        check_outs("force holds", 4'hF, 4'hF, 1'b0);
        bus.force_on = 1'b0;
        tick(IC - 1);
        check("post force edge15", 32'(bus.gate_en), 32'hF);
        tick();
        check("post force edge16", 32'(bus.gate_en), 32'h0);

        // reset while domain 1 is at wake_cnt = 2
        bus.idle     = 4'h0;
        bus.wake_req = 4'b0010;
        tick();
        bus.wake_req = 4'h0;
        tick(3);
        check_outs("d1 mid wake", 4'h2, 4'h0, 1'b1);
        do_reset("reset mid wake");
        tick();
        check_outs("after reset", 4'hF, 4'hF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_gate_controller.md
Name: clock_gate_controller

Overview:
- Per-domain clock-gating sequencer. Drives the enable input of NUM_DOMAINS downstream clock-gating cells from a single controller.
- Gates a domain after it has been idle for IDLE_CYCLES consecutive cycles. Ungates it on a wake request.
- Wake-ups are serialised through a round-robin arbiter, so at most one domain is in its wake window at a time (inrush limiting).
- Sits in the power library between domain activity monitors and the gating cells.

Parameters:
- NUM_DOMAINS, 4: number of gated clock domains (1..16).
- IDLE_CYCLES, 16: consecutive idle cycles required before gating (>=1).
- WAKE_CYCLES, 4: cycles gate_en is high before domain_ready asserts (>=1).
- CNT_W, 8: width of the idle/wake counters. Must hold max(IDLE_CYCLES, WAKE_CYCLES).

Ports:
- clk_in  input  1  free-running controller clock.
- rst_n  input  1  synchronous, active-low reset.
- force_on  input  1  test/override. While high, no domain may be gated and gated domains are woken.
- idle  input  NUM_DOMAINS  per-domain idle indicator, 1 = idle.
- wake_req  input  NUM_DOMAINS  per-domain wake request; level or pulse.
- gate_en  output  NUM_DOMAINS  registered enable to each domain's gating cell, 1 = clock runs.
- domain_ready  output  NUM_DOMAINS  registered, 1 = domain clock is running and stable.
- wake_busy  output  1  registered, 1 = some domain is in WAKE.

Behaviour:
- Reset (rst_n=0 at a clk_in edge):
  - Every domain enters RUN.
  - gate_en = all 1, domain_ready = all 1, wake_busy = 0.
  - All counters = 0, round-robin pointer = 0.
- Each domain runs an independent 4-state FSM: RUN, GATED, WAIT_GRANT, WAKE. Outputs are registered from the next-state value.
- RUN (gate_en=1, ready=1):
  - If idle[i]=1 and force_on=0, idle_cnt increments; otherwise idle_cnt clears to 0.
  - If idle[i]=1, force_on=0 and idle_cnt==IDLE_CYCLES-1, go to GATED. gate_en[i] falls exactly IDLE_CYCLES edges after idle first samples high.
  - A single idle=0 cycle restarts the count.
- GATED (gate_en=0, ready=0):
  - If wake_req[i]=1 or force_on=1, go to WAIT_GRANT.
  - The idle input is ignored.
- WAIT_GRANT (gate_en=0, ready=0):
  - Requests the arbiter. Holds the request until granted; wake_req may deassert meanwhile.
- Arbiter:
  - Issues a grant only in cycles where no domain is in WAKE.
  - Picks the first requesting domain at or after the pointer, searching upward with wrap-around.
  - On a grant, the pointer moves to the granted index + 1, mod NUM_DOMAINS.
  - At most one grant per cycle.
- WAKE (gate_en=1, ready=0, wake_busy=1):
  - wake_cnt counts from 0. When wake_cnt==WAKE_CYCLES-1, go to RUN with idle_cnt=0.
  - domain_ready rises WAKE_CYCLES cycles after gate_en rises.
- Simultaneous events:
  - In GATED, a wake_req arriving in the same cycle the domain entered GATED is honoured on the next cycle; no request is lost.
  - If several requests arrive in the same cycle, grants are issued one per wake window in round-robin order.
  - A back-to-back grant may be issued in the cycle after the previous WAKE completes.
- force_on:
  - Blocks new gating. RUN domains hold idle_cnt at 0.
  - Gated domains wake through the normal arbitrated sequence; force_on never bypasses the arbiter.
- wake_req to a domain in RUN or WAKE is ignored.
- Reset asserted mid-WAKE or mid-WAIT_GRANT: immediately returns all domains to RUN with outputs at their reset values.
- gate_en never glitches: it changes only at clk_in edges and drives the latch-based gating cell's enable.

Test Plan:
- Reset, then idle[0]=1 held, IDLE_CYCLES=16 → gate_en[0] falls on the 16th edge after idle is sampled high. Other domains (idle=0) stay gate_en=1, ready=1.
- idle[1]=1 for 10 cycles, one cycle low, then high → gate_en[1] falls 16 edges after the re-rise, not at 16 edges from the first rise.
- Domain 2 gated, pulse wake_req[2] for 1 cycle → WAIT_GRANT, then gate_en[2]=1 one cycle later. domain_ready[2]=1 exactly 4 cycles after gate_en[2] rises. wake_busy high for those 4 cycles.
- All 4 domains gated, wake_req=4'b1111 in one cycle with pointer=0 → WAKE windows occur in order 0,1,2,3, never overlapping; wake_busy high for 16 cycles total. Repeat with pointer=2 → order 2,3,0,1.
- force_on=1 with domains 0 and 3 gated and idle=all 1 → both woken sequentially (0 then 3). No domain gates while force_on=1. After force_on drops, gating resumes 16 cycles later.
- rst_n=0 for one cycle during domain 1 WAKE (wake_cnt=2) → next cycle gate_en=all 1, domain_ready=all 1, wake_busy=0.
